gearbox_rx_var: RTL and testbench

//  Parametrised Rx gearbox: accepts PMA_W-bit PMA words, emits 66-bit blocks (2-bit sync header + 64-bit payload).

---
 rtl/gearbox_rx_var_if.sv | 24 ++
 rtl/gearbox_rx_var.sv | 94 +++++++++
 tb/tb_gearbox_rx_var.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_rx_var_if.sv
// Rx gearbox bus: PMA word side in, 66-bit block side out.
// The gearbox takes the slave view; the driver/consumer takes the master view.
interface gearbox_rx_var_if #(
    parameter int PMA_W  = 64,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
);
    logic              lock_v_i;
    logic [PMA_W-1:0]  data_i;
    logic              slip_v_i;
    logic              valid_o;
    logic [HEAD_W-1:0] head_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output lock_v_i, data_i, slip_v_i,
        input  valid_o, head_o, data_o
    );

    modport slave (
        input  lock_v_i, data_i, slip_v_i,
        output valid_o, head_o, data_o
    );
endinterface

// File: rtl/gearbox_rx_var.sv
// Parametrised Rx gearbox: PMA_W-bit words in, one 66-bit block (header + payload) out per completion.
// Optional saturating slip counter port enabled by defining GEARBOX_RX_SLIP_CNT_EN.
module gearbox_rx_var #(
    parameter int PMA_W  = 64,
    parameter int HEAD_W = 2,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  nreset,
    gearbox_rx_var_if.slave       rx_if
`ifdef GEARBOX_RX_SLIP_CNT_EN
    ,
    output logic [15:0]           slip_cnt_o
`endif
);
    localparam int BLOCK_W = HEAD_W + DATA_W;
    localparam int BUF_W   = BLOCK_W + PMA_W - 1;
    localparam int FILL_W  = $clog2(BLOCK_W + PMA_W);

    generate
        if (PMA_W < 8 || PMA_W > 64 || PMA_W >= BLOCK_W) begin : g_bad_pma_w
            $error("gearbox_rx_var: PMA_W must be 8..64 and below BLOCK_W");
        end
    endgenerate

    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               valid_q, valid_d;
    logic [BLOCK_W-1:0] blk_q, blk_d;
    logic [BUF_W-1:0]   cat;
    logic [FILL_W-1:0]  avail;

    // Slip drops the oldest bit before the completion test, so a slip can delay a block by a cycle.
    always_comb begin
        cat   = buf_q | (BUF_W'(rx_if.data_i) << fill_q);
        avail = fill_q + FILL_W'(PMA_W);
        if (rx_if.slip_v_i) begin
            cat   = cat >> 1;
            avail = avail - FILL_W'(1);
        end
        buf_d   = cat;
        fill_d  = avail;
        valid_d = 1'b0;
        blk_d   = blk_q;
        if (avail >= FILL_W'(BLOCK_W)) begin
            blk_d   = cat[BLOCK_W-1:0];
            valid_d = 1'b1;
            buf_d   = cat >> BLOCK_W;
            fill_d  = avail - FILL_W'(BLOCK_W);
        end
        if (!rx_if.lock_v_i) begin
            buf_d   = '0;
            fill_d  = '0;
            valid_d = 1'b0;
            blk_d   = blk_q;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            buf_q   <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            blk_q   <= '0;
        end else begin
            buf_q   <= buf_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            blk_q   <= blk_d;
        end
    end

    assign rx_if.valid_o = valid_q;
    assign rx_if.head_o  = blk_q[HEAD_W-1:0];
    assign rx_if.data_o  = blk_q[BLOCK_W-1:HEAD_W];

`ifdef GEARBOX_RX_SLIP_CNT_EN
    logic [15:0] slip_cnt_q, slip_cnt_d;

    // Survives loss of lock on purpose: only reset clears the history.
    always_comb begin
        slip_cnt_d = slip_cnt_q;
        if (rx_if.lock_v_i && rx_if.slip_v_i && slip_cnt_q != 16'hFFFF)
            slip_cnt_d = slip_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) slip_cnt_q <= '0;
        else         slip_cnt_q <= slip_cnt_d;
    end

    assign slip_cnt_o = slip_cnt_q;
`endif
endmodule

// File: tb/tb_gearbox_rx_var.sv
// Bench for gearbox_rx_var: PMA_W=64 and PMA_W=32 instances against a serial bit-queue reference.
// Define GEARBOX_RX_SLIP_CNT_EN to also exercise the slip counter.
module tb_gearbox_rx_var;
    logic clk;
    logic nreset;

    gearbox_rx_var_if #(.PMA_W(64)) if64 ();
    gearbox_rx_var_if #(.PMA_W(32)) if32 ();

`ifdef GEARBOX_RX_SLIP_CNT_EN
    logic [15:0] cnt64, cnt32;
`endif

    gearbox_rx_var #(.PMA_W(64)) dut64 (
        .clk    (clk),
        .nreset (nreset),
        .rx_if  (if64)
`ifdef GEARBOX_RX_SLIP_CNT_EN
        , .slip_cnt_o (cnt64)
`endif
    );

    gearbox_rx_var #(.PMA_W(32)) dut32 (
        .clk    (clk),
        .nreset (nreset),
        .rx_if  (if32)
`ifdef GEARBOX_RX_SLIP_CNT_EN
        , .slip_cnt_o (cnt32)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests;
    int          n_fail;
    int          step_no;
    bit          quiet;
    bit          src[$];          // bits still to be sent, oldest first
    bit          mq[$];           // reference gearbox contents, oldest first
    logic [65:0] expq[$];         // scoreboard of expected blocks
    logic [65:0] orig[$];         // blocks as originally serialised

    // Drive one cycle on the selected instance (other one held out of lock), run the model, check output.
    task automatic step(input int which, input bit lock, input bit slip,
                        output bit got_v, output logic [65:0] got_blk);
        logic [63:0] w;
        logic [65:0] eb;
        bit          exp_v;
        bit          v;
        logic [65:0] blk;
        int          pw;
        pw = (which == 64) ? 64 : 32;
        w  = '0;
        for (int i = 0; i < pw; i++) begin
            if (lock && src.size() > 0) w[i] = src.pop_front();
            else                        w[i] = 1'($urandom_range(0, 1));
        end
        if (which == 64) begin
            if64.lock_v_i = lock; if64.slip_v_i = slip; if64.data_i = w;
            if32.lock_v_i = 1'b0; if32.slip_v_i = 1'b0; if32.data_i = '0;
        end else begin
            if32.lock_v_i = lock; if32.slip_v_i = slip; if32.data_i = w[31:0];
            if64.lock_v_i = 1'b0; if64.slip_v_i = 1'b0; if64.data_i = '0;
        end
        exp_v = 1'b0;
        if (lock) begin
            for (int i = 0; i < pw; i++) mq.push_back(w[i]);
            if (slip) mq.delete(0);
            if (mq.size() >= 66) begin
                for (int i = 0; i < 66; i++) eb[i] = mq.pop_front();
                expq.push_back(eb);
                exp_v = 1'b1;
            end
        end else begin
            mq.delete();
        end
        @(posedge clk);
        #1;
        if (which == 64) begin v = if64.valid_o; blk = {if64.data_o, if64.head_o}; end
        else             begin v = if32.valid_o; blk = {if32.data_o, if32.head_o}; end
        n_tests++;
        if (v !== exp_v) begin
            n_fail++;
            $display("FAIL valid_o step %0d dut%0d: got %b want %b", step_no, which, v, exp_v);
        end
        if (v === 1'b1) begin
            n_tests++;
            if (expq.size() == 0) begin
                n_fail++;
                $display("FAIL block step %0d dut%0d: got %h want none", step_no, which, blk);
            end else begin
                eb = expq.pop_front();
                if (blk !== eb) begin
                    n_fail++;
                    $display("FAIL block step %0d dut%0d: got %h want %h", step_no, which, blk, eb);
                end else if (!quiet) begin
                    $display("[TB] step %0d dut%0d block head=%b data=%h", step_no, which, blk[1:0], blk[65:2]);
                end
            end
        end
        got_v   = v;
        got_blk = blk;
        step_no++;
        @(negedge clk);
    endtask

    task automatic flush(input int which);
        bit          v;
        logic [65:0] b;
        src.delete();
        orig.delete();
        step(which, 1'b0, 1'b0, v, b);
    endtask

    task automatic load_stream(input int nblk, input int pre);
        logic [65:0] blk;
        src.delete();
        orig.delete();
        for (int i = 0; i < pre; i++) src.push_back(1'($urandom_range(0, 1)));
        for (int b = 0; b < nblk; b++) begin
            blk[65:34] = $urandom;
            blk[33:2]  = $urandom;
            blk[1:0]   = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
            orig.push_back(blk);
            for (int i = 0; i < 66; i++) src.push_back(blk[i]);
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(negedge clk);
        n_tests += 6;
        if (if64.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset valid64: got %b want 0", if64.valid_o); end
        if (if64.head_o !== 2'b00) begin n_fail++; $display("FAIL reset head64: got %b want 00", if64.head_o); end
        if (if64.data_o !== 64'd0) begin n_fail++; $display("FAIL reset data64: got %h want 0", if64.data_o); end
        if (if32.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset valid32: got %b want 0", if32.valid_o); end
        if (if32.head_o !== 2'b00) begin n_fail++; $display("FAIL reset head32: got %b want 00", if32.head_o); end
        if (if32.data_o !== 64'd0) begin n_fail++; $display("FAIL reset data32: got %h want 0", if32.data_o); end
`ifdef GEARBOX_RX_SLIP_CNT_EN
        n_tests++;
        if (cnt64 !== 16'd0) begin n_fail++; $display("FAIL reset slip_cnt: got %h want 0", cnt64); end
`endif
        nreset = 1'b1;
        mq.delete();
        expq.delete();
        $display("[TB] reset done");
    endtask

    task automatic test_rate(input int which, input int nwords, input int first_want, input int rate_want);
        bit          v;
        logic [65:0] b;
        logic [65:0] ob;
        int          first;
        int          cnt;
        flush(which);
        load_stream(66, 0);
        first = -1;
        cnt   = 0;
        for (int k = 0; k < nwords; k++) begin
            step(which, 1'b1, 1'b0, v, b);
            if (v) begin
                if (first < 0) first = k;
                if (k >= first_want && k < first_want + 33) cnt++;
                n_tests++;
                if (orig.size() == 0) begin
                    n_fail++;
                    $display("FAIL order dut%0d: got extra block %h want none", which, b);
                end else begin
                    ob = orig.pop_front();
                    if (b !== ob) begin
                        n_fail++;
                        $display("FAIL order dut%0d: got %h want %h", which, b, ob);
                    end
                end
            end
        end
        n_tests += 3;
        if (first !== first_want) begin n_fail++; $display("FAIL first_valid dut%0d: got %0d want %0d", which, first, first_want); end
        if (cnt !== rate_want) begin n_fail++; $display("FAIL rate dut%0d: got %0d want %0d per 33", which, cnt, rate_want); end
        if (orig.size() !== 0) begin n_fail++; $display("FAIL blocks_out dut%0d: got %0d left want 0", which, orig.size()); end
    endtask

    task automatic test_slip_align();
        bit          v;
        logic [65:0] b;
        flush(64);
        load_stream(20, 5);
        for (int k = 0; k < 21; k++) begin
            step(64, 1'b1, (k < 5), v, b);
            if (v && k >= 4) begin
                n_tests++;
                if (b[1:0] !== 2'b01 && b[1:0] !== 2'b10) begin
                    n_fail++;
                    $display("FAIL slip_head step %0d: got %b want 01/10", k, b[1:0]);
                end
            end
        end
    endtask

    task automatic test_lock_drop();
        bit          v;
        logic [65:0] b;
        logic [65:0] ob;
        int          first;
        flush(64);
        for (int k = 0; k < 13; k++) step(64, 1'b1, 1'b0, v, b);
        step(64, 1'b0, 1'b1, v, b);
        n_tests++;
        if (v !== 1'b0) begin n_fail++; $display("FAIL lock_drop valid: got %b want 0", v); end
        load_stream(3, 0);
        first = -1;
        for (int k = 0; k < 4; k++) begin
            step(64, 1'b1, 1'b0, v, b);
            if (v) begin
                if (first < 0) first = k;
                ob = orig.pop_front();
                n_tests++;
                if (b !== ob) begin n_fail++; $display("FAIL relock_block: got %h want %h", b, ob); end
            end
        end
        n_tests++;
        if (first !== 1) begin n_fail++; $display("FAIL relock_first: got %0d want 1", first); end
    endtask

    task automatic test_slip_boundary();
        bit          v;
        logic [65:0] b;
        flush(64);
        for (int k = 0; k < 32; k++) step(64, 1'b1, 1'b0, v, b);
        step(64, 1'b1, 1'b1, v, b);
        n_tests++;
        if (v !== 1'b0) begin n_fail++; $display("FAIL slip_boundary valid: got %b want 0", v); end
        step(64, 1'b1, 1'b0, v, b);
        n_tests++;
        if (v !== 1'b1) begin n_fail++; $display("FAIL slip_boundary late: got %b want 1", v); end
    endtask

    task automatic test_async_reset();
        @(posedge clk);
        #3;
        nreset = 1'b0;
        #1;
        n_tests += 3;
        if (if64.valid_o !== 1'b0) begin n_fail++; $display("FAIL async_valid: got %b want 0", if64.valid_o); end
        if (if64.head_o !== 2'b00) begin n_fail++; $display("FAIL async_head: got %b want 00", if64.head_o); end
        if (if64.data_o !== 64'd0) begin n_fail++; $display("FAIL async_data: got %h want 0", if64.data_o); end
`ifdef GEARBOX_RX_SLIP_CNT_EN
        n_tests++;
        if (cnt64 !== 16'd0) begin n_fail++; $display("FAIL async_slip_cnt: got %h want 0", cnt64); end
`endif
        @(negedge clk);
        nreset = 1'b1;
        mq.delete();
        expq.delete();
        $display("[TB] async reset done");
    endtask

`ifdef GEARBOX_RX_SLIP_CNT_EN
    task automatic test_slip_cnt();
        bit          v;
        logic [65:0] b;
        test_async_reset();
        quiet = 1'b1;
        for (int k = 0; k < 10; k++) step(64, 1'b1, 1'b1, v, b);
        n_tests++;
        if (cnt64 !== 16'd10) begin n_fail++; $display("FAIL slip_cnt_10: got %0d want 10", cnt64); end
        step(64, 1'b0, 1'b1, v, b);
        n_tests++;
        if (cnt64 !== 16'd10) begin n_fail++; $display("FAIL slip_cnt_unlock: got %0d want 10", cnt64); end
        for (int k = 0; k < 69990; k++) step(64, 1'b1, 1'b1, v, b);
        n_tests++;
        if (cnt64 !== 16'hFFFF) begin n_fail++; $display("FAIL slip_cnt_sat: got %h want ffff", cnt64); end
        quiet = 1'b0;
        test_async_reset();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        step_no = 0;
        quiet   = 1'b0;
        nreset  = 1'b0;
        if64.lock_v_i = 1'b0; if64.slip_v_i = 1'b0; if64.data_i = '0;
        if32.lock_v_i = 1'b0; if32.slip_v_i = 1'b0; if32.data_i = '0;
        @(negedge clk);
        test_reset();
        test_rate(64, 69, 1, 32);
        test_rate(32, 137, 2, 16);
        test_slip_align();
        test_lock_drop();
        test_slip_boundary();
        test_async_reset();
`ifdef GEARBOX_RX_SLIP_CNT_EN
        test_slip_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
